// File: rtl/axi_lite_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axi_lite_rr_arbiter
//
// Round-robin arbiter that lets NUM_MASTERS masters share one AXI4-Lite slave
// path. A single master is granted at a time. Its grant is held until the
// closing handshake of its transaction: B for a write, R for a read. The
// registered grant drives the interconnect's AW/W/AR/R/B steering muxes.
//
// Optional feature: define ARB_TIMEOUT_EN to enable a watchdog. The watchdog
// force-releases a grant that has waited TIMEOUT_CYCLES cycles without its
// handshake, and pulses timeout_err for one cycle. When the macro is not
// defined, timeout_err is tied to 0 and a grant is held indefinitely.
//
// Ports:
//   aclk         clock, rising edge
//   areset_n     asynchronous active-low reset
//   req          per-master request, held until granted and the transaction is done
//   req_wr       per-master transaction type (1 = write, 0 = read)
//   b_hs         bvalid & bready on the shared path
//   r_hs         rvalid & rready on the shared path
//   grant        one-hot grant (registered)
//   grant_idx    binary index of the granted master
//   grant_valid  a grant is active
//   grant_wr     type of the granted transaction
//   timeout_err  one-cycle pulse when the watchdog forces a release
// -----------------------------------------------------------------------------
module axi_lite_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int IDX_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   aclk,
    input  logic                   areset_n,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] req_wr,
    input  logic                   b_hs,
    input  logic                   r_hs,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   grant_valid,
    output logic                   grant_wr,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_WR = 2'd1,
        BUSY_RD = 2'd2
    } state_t;

    state_t                 state, state_nx;
    logic [IDX_W-1:0]       last, last_nx;
    logic [NUM_MASTERS-1:0] grant_nx;
    logic [IDX_W-1:0]       grant_idx_nx;
    logic                   grant_valid_nx;
    logic                   grant_wr_nx;

    logic                   sel_found;
    logic [IDX_W-1:0]       sel_idx;
    logic                   hs_done;
    logic                   tmo_hit;
    logic                   new_grant;

    // Rotating priority search. It starts one position past the last owner, so
    // the previous owner drops to lowest priority.
    always_comb begin
        int unsigned cand;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = (int'(last) + k) % NUM_MASTERS;
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end

    // Only the handshake that matches the granted type closes the transaction.
    assign hs_done   = ((state == BUSY_WR) && b_hs) || ((state == BUSY_RD) && r_hs);
    assign new_grant = (state == IDLE) && sel_found;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;

    // A handshake on the limit cycle wins over the watchdog.
    assign tmo_hit = (state != IDLE) && !hs_done &&
                     (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_hit;
            if (new_grant) begin
                tmo_cnt <= '0;
            end else if ((state != IDLE) && !hs_done) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state and next-grant logic
    always_comb begin
        state_nx       = state;
        last_nx        = last;
        grant_nx       = grant;
        grant_idx_nx   = grant_idx;
        grant_valid_nx = grant_valid;
        grant_wr_nx    = grant_wr;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    grant_nx       = NUM_MASTERS'(1) << sel_idx;
                    grant_idx_nx   = sel_idx;
                    grant_valid_nx = 1'b1;
                    grant_wr_nx    = req_wr[sel_idx];
                    last_nx        = sel_idx;
                    state_nx       = req_wr[sel_idx] ? BUSY_WR : BUSY_RD;
                end
            end
            BUSY_WR, BUSY_RD: begin
                if (hs_done || tmo_hit) begin
                    grant_nx       = '0;
                    grant_idx_nx   = '0;
                    grant_valid_nx = 1'b0;
                    grant_wr_nx    = 1'b0;
                    state_nx       = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and grant registers
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state       <= IDLE;
            last        <= IDX_W'(NUM_MASTERS - 1);
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            grant_wr    <= 1'b0;
        end else begin
            state       <= state_nx;
            last        <= last_nx;
            grant       <= grant_nx;
            grant_idx   <= grant_idx_nx;
            grant_valid <= grant_valid_nx;
            grant_wr    <= grant_wr_nx;
        end
    end

    // Structural invariants of the grant outputs
    a_param_ok: assert property (@(posedge aclk) (TIMEOUT_CYCLES > 1) && (NUM_MASTERS > 1));
    a_onehot:   assert property (@(posedge aclk) disable iff (!areset_n) $onehot0(grant));
    a_valid:    assert property (@(posedge aclk) disable iff (!areset_n) grant_valid == (|grant));
    a_idx:      assert property (@(posedge aclk) disable iff (!areset_n)
                                 grant_valid |-> grant[grant_idx]);

endmodule
